// File: rtl/pipe_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pipe_ctrl_if                                                 |
// | Description : Handshake bundle between the pipeline datapath and the       |
// |               pipeline controller. The datapath (master) reports RF-stage  |
// |               decode info, branch outcome, memory readiness and interrupt  |
// |               status; the controller (slave) returns stall/annul/freeze    |
// |               controls and per-stage destination registers for bypassing. |
// | Ports       : master -> rf_valid, rf_ra, rf_rb, rf_rc, rf_use_ra,          |
// |                         rf_use_rb, rf_is_ld, rf_is_mem, ex_br_taken,       |
// |                         dmem_ready, irq, supervisor                        |
// |               slave  -> stall_if, stall_rf, annul_if, annul_rf, freeze,    |
// |                         rc_ex, rc_mem, rc_wb, wb_we, irq_take              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface pipe_ctrl_if #(
  parameter int NREG = 5
);

  // Datapath -> controller
  logic            rf_valid;
  logic [NREG-1:0] rf_ra;
  logic [NREG-1:0] rf_rb;
  logic [NREG-1:0] rf_rc;
  logic            rf_use_ra;
  logic            rf_use_rb;
  logic            rf_is_ld;
  logic            rf_is_mem;
  logic            ex_br_taken;
  logic            dmem_ready;
  logic            irq;
  logic            supervisor;

  // Controller -> datapath
  logic            stall_if;
  logic            stall_rf;
  logic            annul_if;
  logic            annul_rf;
  logic            freeze;
  logic [NREG-1:0] rc_ex;
  logic [NREG-1:0] rc_mem;
  logic [NREG-1:0] rc_wb;
  logic            wb_we;
  logic            irq_take;

  modport master (
    output rf_valid, rf_ra, rf_rb, rf_rc, rf_use_ra, rf_use_rb,
           rf_is_ld, rf_is_mem, ex_br_taken, dmem_ready, irq, supervisor,
    input  stall_if, stall_rf, annul_if, annul_rf, freeze,
           rc_ex, rc_mem, rc_wb, wb_we, irq_take
  );

  modport slave (
    input  rf_valid, rf_ra, rf_rb, rf_rc, rf_use_ra, rf_use_rb,
           rf_is_ld, rf_is_mem, ex_br_taken, dmem_ready, irq, supervisor,
    output stall_if, stall_rf, annul_if, annul_rf, freeze,
           rc_ex, rc_mem, rc_wb, wb_we, irq_take
  );

endinterface
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pipe_ctrl                                                    |
// | Description : Control unit for a 5-stage (IF/RF/EX/MEM/WB) pipeline.       |
// |               Tracks the instruction occupying EX, MEM and WB, detects     |
// |               load-use hazards, freezes the pipe on data-memory wait,      |
// |               annuls fetch/decode on taken branches and sequences external |
// |               interrupts through a small IDLE/ARMED/TAKE machine.          |
// | Ports       : clk        - sole clock, rising edge                         |
// |               rst_n      - asynchronous active-low reset                   |
// |               bus        - pipe_ctrl_if.slave (RF decode info in,          |
// |                            stall/annul/freeze/bypass/write-enable out)     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pipe_ctrl #(
  parameter int NREG = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  pipe_ctrl_if.slave bus
);

  // Register R31 (all ones) is hard-wired zero: never written, never a hazard.
  localparam logic [NREG-1:0] c_zero_reg = '1;

  // Stage record for EX and MEM. WB keeps only valid/rc: nothing past MEM
  // consumes the load/memory flags.
  typedef struct packed {
    logic            valid;
    logic [NREG-1:0] rc;
    logic            is_ld;
    logic            is_mem;
  } stage_t;

  typedef struct packed {
    logic            valid;
    logic [NREG-1:0] rc;
  } wb_stage_t;

  localparam stage_t    c_bubble    = {1'b0, c_zero_reg, 1'b0, 1'b0};
  localparam wb_stage_t c_wb_bubble = {1'b0, c_zero_reg};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ARMED = 2'b01,
    ST_TAKE  = 2'b10
  } irq_state_e;

  stage_t     r_ex;
  stage_t     r_mem;
  wb_stage_t  r_wb;
  irq_state_e r_irq_state;
  irq_state_e w_irq_next;

  stage_t     w_ex_next;
  logic       w_freeze;
  logic       w_branch;
  logic       w_hit_ex;
  logic       w_hit_mem;
  logic       w_hazard;
  logic       w_take;
  logic       w_lu_stall;
  logic       w_stall;

  // A stage blocks the RF instruction when it holds a valid load whose
  // destination (other than R31) is one of the registers RF actually reads.
  function automatic logic load_blocks(
    input stage_t          s,
    input logic            use_ra,
    input logic [NREG-1:0] ra,
    input logic            use_rb,
    input logic [NREG-1:0] rb
  );
    return s.valid && s.is_ld && (s.rc != c_zero_reg) &&
           ((use_ra && (ra == s.rc)) || (use_rb && (rb == s.rc)));
  endfunction

  // --------------------------------------------------------------------------
  // Hazard and priority resolution: freeze > branch > interrupt > load-use
  // --------------------------------------------------------------------------
  always_comb begin
    w_freeze   = r_mem.valid && r_mem.is_mem && !bus.dmem_ready;
    w_branch   = bus.ex_br_taken && r_ex.valid && !w_freeze;
    w_hit_ex   = load_blocks(r_ex,  bus.rf_use_ra, bus.rf_ra, bus.rf_use_rb, bus.rf_rb);
    w_hit_mem  = load_blocks(r_mem, bus.rf_use_ra, bus.rf_ra, bus.rf_use_rb, bus.rf_rb);
    w_hazard   = bus.rf_valid && (w_hit_ex || w_hit_mem);
    // The interrupt is only taken in user mode; a supervisor transition while
    // in TAKE cancels it rather than redirecting kernel code.
    w_take     = (r_irq_state == ST_TAKE) && !w_freeze && !w_branch && !bus.supervisor;
    w_lu_stall = w_hazard && !w_freeze && !w_branch && !w_take;
    w_stall    = w_freeze || w_lu_stall;
  end

  // --------------------------------------------------------------------------
  // Next EX contents: a bubble whenever RF is held, annulled or empty. On an
  // interrupt take the RF instruction proceeds so its PC becomes the saved XP.
  // --------------------------------------------------------------------------
  always_comb begin
    w_ex_next = c_bubble;
    if (!w_stall && !w_branch && bus.rf_valid) begin
      w_ex_next.valid  = 1'b1;
      w_ex_next.rc     = bus.rf_rc;
      w_ex_next.is_ld  = bus.rf_is_ld;
      w_ex_next.is_mem = bus.rf_is_mem;
    end
  end

  // --------------------------------------------------------------------------
  // Stage tracking registers: hold everything while frozen.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex  <= c_bubble;
      r_mem <= c_bubble;
      r_wb  <= c_wb_bubble;
    end else if (!w_freeze) begin
      r_ex     <= w_ex_next;
      r_mem    <= r_ex;
      r_wb.valid <= r_mem.valid;
      r_wb.rc    <= r_mem.rc;
    end
  end

  // --------------------------------------------------------------------------
  // Interrupt FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_irq_state <= ST_IDLE;
    end else begin
      r_irq_state <= w_irq_next;
    end
  end

  always_comb begin
    w_irq_next = r_irq_state;
    case (r_irq_state)
      ST_IDLE: begin
        if (bus.irq && !bus.supervisor) begin
          w_irq_next = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (!bus.irq || bus.supervisor) begin
          w_irq_next = ST_IDLE;
        end else if (!w_freeze && !w_branch && !w_hazard) begin
          w_irq_next = ST_TAKE;
        end
      end
      ST_TAKE: begin
        // irq level is no longer consulted here. A freeze or branch that
        // pre-empts the take keeps the request pending until it can retire.
        if (!w_freeze && !w_branch) begin
          w_irq_next = ST_IDLE;
        end
      end
      default: begin
        w_irq_next = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.freeze   = w_freeze;
  assign bus.stall_if = w_stall;
  assign bus.stall_rf = w_stall;
  assign bus.annul_if = w_branch || w_take;
  assign bus.annul_rf = w_branch;
  assign bus.irq_take = w_take;

  // Empty stages present R31 so bypass compares can never match them.
  assign bus.rc_ex  = r_ex.valid  ? r_ex.rc  : c_zero_reg;
  assign bus.rc_mem = r_mem.valid ? r_mem.rc : c_zero_reg;
  assign bus.rc_wb  = r_wb.valid  ? r_wb.rc  : c_zero_reg;
  assign bus.wb_we  = r_wb.valid && (r_wb.rc != c_zero_reg) && !w_freeze;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_pipe_ctrl                                                 |
// | Description : Self-checking bench for pipe_ctrl: directed scenarios plus   |
// |               a randomized run against a behavioural pipeline model.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_pipe_ctrl;

  localparam int NREG = 5;
  localparam logic [NREG-1:0] R31 = '1;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  pipe_ctrl_if #(.NREG(NREG)) bus ();

  pipe_ctrl #(.NREG(NREG)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fails  = 0;

  // ---------------------------------------------------------------- helpers
  function automatic logic [6:0] flags();
    return {bus.stall_if, bus.stall_rf, bus.annul_if, bus.annul_rf,
            bus.freeze, bus.wb_we, bus.irq_take};
  endfunction

  task automatic drive_idle();
    bus.rf_valid    = 1'b0;
    bus.rf_ra       = '0;
    bus.rf_rb       = '0;
    bus.rf_rc       = R31;
    bus.rf_use_ra   = 1'b0;
    bus.rf_use_rb   = 1'b0;
    bus.rf_is_ld    = 1'b0;
    bus.rf_is_mem   = 1'b0;
    bus.ex_br_taken = 1'b0;
    bus.dmem_ready  = 1'b1;
    bus.irq         = 1'b0;
    bus.supervisor  = 1'b0;
  endtask

  task automatic drive_instr(input logic [NREG-1:0] rc, input logic [NREG-1:0] ra,
                             input logic [NREG-1:0] rb, input logic ua, input logic ub,
                             input logic ld, input logic mem);
    bus.rf_valid  = 1'b1;
    bus.rf_rc     = rc;
    bus.rf_ra     = ra;
    bus.rf_rb     = rb;
    bus.rf_use_ra = ua;
    bus.rf_use_rb = ub;
    bus.rf_is_ld  = ld;
    bus.rf_is_mem = mem;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    drive_idle();
    next_cycle();
    rst_n = 1'b1;
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    rst_n = 1'b0;
    drive_idle();
    #2;
    n_checks++;
    if (flags() !== 7'b0) begin
      n_fails++; $display("FAIL reset_flags got=%b exp=%b", flags(), 7'b0);
    end
    n_checks++;
    if (bus.rc_ex !== R31) begin
      n_fails++; $display("FAIL reset_rc_ex got=%0d exp=31", bus.rc_ex);
    end
    n_checks++;
    if (bus.rc_mem !== R31) begin
      n_fails++; $display("FAIL reset_rc_mem got=%0d exp=31", bus.rc_mem);
    end
    n_checks++;
    if (bus.rc_wb !== R31) begin
      n_fails++; $display("FAIL reset_rc_wb got=%0d exp=31", bus.rc_wb);
    end
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (flags() !== 7'b0) begin
      n_fails++; $display("FAIL reset_release_flags got=%b exp=%b", flags(), 7'b0);
    end
    next_cycle();
  endtask

  task automatic test_load_use();
    logic [NREG-1:0] exp_rc;
    apply_reset();
    drive_instr(5'd1, 5'd2, 5'd2, 1'b0, 1'b0, 1'b1, 1'b1);   // LD -> R1
    @(negedge clk);
    n_checks++;
    if (bus.stall_rf !== 1'b0) begin
      n_fails++; $display("FAIL lu_ld_alone stall_rf got=%b exp=0", bus.stall_rf);
    end
    next_cycle();
    drive_instr(5'd3, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0);   // ADD R1,R2 -> R3
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      exp_rc = (c == 0) ? 5'd1 : R31;
      n_checks++;
      if ({bus.stall_if, bus.stall_rf} !== 2'b11) begin
        n_fails++; $display("FAIL lu_stall c=%0d got=%b exp=11", c, {bus.stall_if, bus.stall_rf});
      end
      n_checks++;
      if (bus.rc_ex !== exp_rc) begin
        n_fails++; $display("FAIL lu_rc_ex c=%0d got=%0d exp=%0d", c, bus.rc_ex, exp_rc);
      end
      next_cycle();
    end
    @(negedge clk);
    n_checks++;
    if (bus.stall_rf !== 1'b0) begin
      n_fails++; $display("FAIL lu_release stall_rf got=%b exp=0", bus.stall_rf);
    end
    n_checks++;
    if (bus.rc_ex !== R31) begin
      n_fails++; $display("FAIL lu_second_bubble rc_ex got=%0d exp=31", bus.rc_ex);
    end
    n_checks++;
    if ({bus.wb_we, bus.rc_wb} !== {1'b1, 5'd1}) begin
      n_fails++; $display("FAIL lu_ld_wb got we=%b rc=%0d exp we=1 rc=1", bus.wb_we, bus.rc_wb);
    end
    next_cycle();
    drive_idle();
    @(negedge clk);
    n_checks++;
    if (bus.rc_ex !== 5'd3) begin
      n_fails++; $display("FAIL lu_add_in_ex rc_ex got=%0d exp=3", bus.rc_ex);
    end
    next_cycle();
  endtask

  task automatic test_mem_freeze();
    apply_reset();
    drive_instr(5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);   // ADD -> R5
    next_cycle();
    drive_instr(R31, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);    // ST
    next_cycle();
    drive_idle();
    next_cycle();                                           // MEM=ST, WB=ADD
    drive_instr(5'd9, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.dmem_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if ({bus.freeze, bus.stall_if, bus.stall_rf, bus.annul_if, bus.annul_rf} !== 5'b11100) begin
        n_fails++; $display("FAIL frz_ctrl c=%0d got=%b exp=11100", c,
          {bus.freeze, bus.stall_if, bus.stall_rf, bus.annul_if, bus.annul_rf});
      end
      n_checks++;
      if ({bus.rc_ex, bus.rc_mem, bus.rc_wb} !== {R31, R31, 5'd5}) begin
        n_fails++; $display("FAIL frz_rc c=%0d got=%0d/%0d/%0d exp=31/31/5", c,
          bus.rc_ex, bus.rc_mem, bus.rc_wb);
      end
      n_checks++;
      if (bus.wb_we !== 1'b0) begin
        n_fails++; $display("FAIL frz_wb_we c=%0d got=%b exp=0", c, bus.wb_we);
      end
      next_cycle();
    end
    bus.dmem_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({bus.freeze, bus.wb_we, bus.rc_wb} !== {1'b0, 1'b1, 5'd5}) begin
      n_fails++; $display("FAIL frz_end got frz=%b we=%b rc_wb=%0d exp 0/1/5",
        bus.freeze, bus.wb_we, bus.rc_wb);
    end
    next_cycle();
    drive_idle();
    @(negedge clk);
    n_checks++;
    if ({bus.rc_ex, bus.rc_wb, bus.wb_we} !== {5'd9, R31, 1'b0}) begin
      n_fails++; $display("FAIL frz_resume got rc_ex=%0d rc_wb=%0d we=%b exp 9/31/0",
        bus.rc_ex, bus.rc_wb, bus.wb_we);
    end
    next_cycle();
  endtask

  task automatic test_branch_hazard();
    apply_reset();
    drive_instr(5'd4, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);   // LD -> R4
    next_cycle();
    drive_instr(R31, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);    // BEQ
    next_cycle();                                           // EX=BEQ, MEM=LD
    drive_instr(5'd6, 5'd4, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);   // uses R4
    bus.ex_br_taken = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({bus.annul_if, bus.annul_rf, bus.stall_if, bus.stall_rf, bus.irq_take} !== 5'b11000) begin
      n_fails++; $display("FAIL br_ctrl got=%b exp=11000",
        {bus.annul_if, bus.annul_rf, bus.stall_if, bus.stall_rf, bus.irq_take});
    end
    next_cycle();
    drive_idle();
    @(negedge clk);
    n_checks++;
    if (bus.rc_ex !== R31) begin
      n_fails++; $display("FAIL br_bubble rc_ex got=%0d exp=31", bus.rc_ex);
    end
    next_cycle();
  endtask

  task automatic test_irq();
    logic exp_take;
    apply_reset();
    bus.irq = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (c == 3) bus.irq = 1'b0;
      @(negedge clk);
      exp_take = (c == 2);
      n_checks++;
      if (bus.irq_take !== exp_take) begin
        n_fails++; $display("FAIL irq_take c=%0d got=%b exp=%b", c, bus.irq_take, exp_take);
      end
      n_checks++;
      if ({bus.annul_if, bus.annul_rf, bus.stall_rf} !== {exp_take, 1'b0, 1'b0}) begin
        n_fails++; $display("FAIL irq_ctrl c=%0d got=%b exp=%b", c,
          {bus.annul_if, bus.annul_rf, bus.stall_rf}, {exp_take, 1'b0, 1'b0});
      end
      next_cycle();
    end
  endtask

  task automatic test_irq_supervisor();
    logic exp_take;
    apply_reset();
    bus.irq        = 1'b1;
    bus.supervisor = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_checks++;
      if ({bus.irq_take, bus.annul_if} !== 2'b00) begin
        n_fails++; $display("FAIL sup_blocked c=%0d got=%b exp=00", c, {bus.irq_take, bus.annul_if});
      end
      next_cycle();
    end
    // Leaving supervisor mode must start from IDLE: take lands two cycles on.
    bus.supervisor = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      exp_take = (c == 2);
      n_checks++;
      if (bus.irq_take !== exp_take) begin
        n_fails++; $display("FAIL sup_idle c=%0d irq_take got=%b exp=%b", c, bus.irq_take, exp_take);
      end
      next_cycle();
    end
    drive_idle();
    next_cycle();
  endtask

  task automatic test_reset_during_freeze();
    apply_reset();
    drive_instr(R31, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);    // ST
    next_cycle();
    drive_idle();
    next_cycle();
    bus.dmem_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.freeze !== 1'b1) begin
      n_fails++; $display("FAIL rstfrz_pre freeze got=%b exp=1", bus.freeze);
    end
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (flags() !== 7'b0) begin
      n_fails++; $display("FAIL rstfrz_async flags got=%b exp=0000000", flags());
    end
    n_checks++;
    if ({bus.rc_ex, bus.rc_mem, bus.rc_wb} !== {R31, R31, R31}) begin
      n_fails++; $display("FAIL rstfrz_async rc got=%0d/%0d/%0d exp=31/31/31",
        bus.rc_ex, bus.rc_mem, bus.rc_wb);
    end
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (flags() !== 7'b0) begin
      n_fails++; $display("FAIL rstfrz_resume flags got=%b exp=0000000", flags());
    end
    drive_idle();
    next_cycle();
  endtask

  // ---------------------------------------------------------------- random
  typedef struct {
    bit v;
    int rc;
    bit ld;
    bit mem;
  } slot_t;

  function automatic logic [NREG-1:0] pick_reg();
    int k;
    k = $urandom_range(0, 4);
    if (k == 4) return NREG'($urandom_range(0, 31));
    if (k == 3) return R31;
    return NREG'(k + 1);
  endfunction

  task automatic test_random(input int n_cycles);
    slot_t pipe [3];           // 0 = EX, 1 = MEM, 2 = WB
    int    pending;            // 0 no request, 1 waiting for a clean cycle, 2 taking
    bit    frz, br, haz, take, lu, e_stall, e_aif, e_arf, e_we;
    int    e_rc [3];
    slot_t empty;
    empty = '{v: 1'b0, rc: 31, ld: 1'b0, mem: 1'b0};
    apply_reset();
    for (int s = 0; s < 3; s++) pipe[s] = empty;
    pending = 0;
    for (int cyc = 0; cyc < n_cycles; cyc++) begin
      bus.rf_valid    = ($urandom_range(0, 9) < 8);
      bus.rf_ra       = pick_reg();
      bus.rf_rb       = pick_reg();
      bus.rf_rc       = pick_reg();
      bus.rf_use_ra   = $urandom_range(0, 1) == 1;
      bus.rf_use_rb   = $urandom_range(0, 1) == 1;
      bus.rf_is_ld    = ($urandom_range(0, 9) < 3);
      bus.rf_is_mem   = bus.rf_is_ld || ($urandom_range(0, 9) < 2);
      bus.ex_br_taken = ($urandom_range(0, 99) < 15);
      bus.dmem_ready  = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 9) == 0) bus.irq = ~bus.irq;
      if ($urandom_range(0, 9) == 0) bus.supervisor = ~bus.supervisor;
      @(negedge clk);

      frz = pipe[1].v && pipe[1].mem && !bus.dmem_ready;
      br  = bus.ex_br_taken && pipe[0].v && !frz;
      haz = 1'b0;
      for (int s = 0; s < 2; s++) begin
        if (bus.rf_valid && pipe[s].v && pipe[s].ld && pipe[s].rc != 31 &&
            ((bus.rf_use_ra && int'(bus.rf_ra) == pipe[s].rc) ||
             (bus.rf_use_rb && int'(bus.rf_rb) == pipe[s].rc)))
          haz = 1'b1;
      end
      take    = (pending == 2) && !frz && !br && !bus.supervisor;
      lu      = haz && !frz && !br && !take;
      e_stall = frz || lu;
      e_aif   = br || take;
      e_arf   = br;
      e_we    = pipe[2].v && pipe[2].rc != 31 && !frz;
      for (int s = 0; s < 3; s++) e_rc[s] = pipe[s].v ? pipe[s].rc : 31;

      n_checks++;
      if (bus.freeze !== frz) begin
        n_fails++; $display("FAIL rnd_freeze cyc=%0d got=%b exp=%b", cyc, bus.freeze, frz);
      end
      n_checks++;
      if (bus.stall_if !== e_stall) begin
        n_fails++; $display("FAIL rnd_stall_if cyc=%0d got=%b exp=%b", cyc, bus.stall_if, e_stall);
      end
      n_checks++;
      if (bus.stall_rf !== e_stall) begin
        n_fails++; $display("FAIL rnd_stall_rf cyc=%0d got=%b exp=%b", cyc, bus.stall_rf, e_stall);
      end
      n_checks++;
      if (bus.annul_if !== e_aif) begin
        n_fails++; $display("FAIL rnd_annul_if cyc=%0d got=%b exp=%b", cyc, bus.annul_if, e_aif);
      end
      n_checks++;
      if (bus.annul_rf !== e_arf) begin
        n_fails++; $display("FAIL rnd_annul_rf cyc=%0d got=%b exp=%b", cyc, bus.annul_rf, e_arf);
      end
      n_checks++;
      if (bus.irq_take !== take) begin
        n_fails++; $display("FAIL rnd_irq_take cyc=%0d got=%b exp=%b", cyc, bus.irq_take, take);
      end
      n_checks++;
      if (bus.wb_we !== e_we) begin
        n_fails++; $display("FAIL rnd_wb_we cyc=%0d got=%b exp=%b", cyc, bus.wb_we, e_we);
      end
      n_checks++;
      if (int'(bus.rc_ex) != e_rc[0]) begin
        n_fails++; $display("FAIL rnd_rc_ex cyc=%0d got=%0d exp=%0d", cyc, bus.rc_ex, e_rc[0]);
      end
      n_checks++;
      if (int'(bus.rc_mem) != e_rc[1]) begin
        n_fails++; $display("FAIL rnd_rc_mem cyc=%0d got=%0d exp=%0d", cyc, bus.rc_mem, e_rc[1]);
      end
      n_checks++;
      if (int'(bus.rc_wb) != e_rc[2]) begin
        n_fails++; $display("FAIL rnd_rc_wb cyc=%0d got=%0d exp=%0d", cyc, bus.rc_wb, e_rc[2]);
      end

      if ($urandom_range(0, 99) == 0) begin
        // Occasional asynchronous reset in mid-cycle: pipeline empties.
        #1 rst_n = 1'b0;
        for (int s = 0; s < 3; s++) pipe[s] = empty;
        pending = 0;
        next_cycle();
        rst_n = 1'b1;
      end else begin
        if (!frz) begin
          pipe[2] = pipe[1];
          pipe[1] = pipe[0];
          if (e_stall || br || !bus.rf_valid)
            pipe[0] = empty;
          else
            pipe[0] = '{v: 1'b1, rc: int'(bus.rf_rc), ld: bus.rf_is_ld, mem: bus.rf_is_mem};
        end
        if (pending == 0) begin
          if (bus.irq && !bus.supervisor) pending = 1;
        end else if (pending == 1) begin
          if (!bus.irq || bus.supervisor) pending = 0;
          else if (!frz && !br && !haz) pending = 2;
        end else begin
          if (!frz && !br) pending = 0;
        end
        next_cycle();
      end
    end
    drive_idle();
  endtask

  // ---------------------------------------------------------------- main
  initial begin
    test_reset();
    test_load_use();
    test_mem_freeze();
    test_branch_hazard();
    test_irq();
    test_irq_supervisor();
    test_reset_during_freeze();
    test_random(3000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
